// File: rtl/mips_cpu_regfile_pkg.sv
// Shared MIPS CPU definitions: register-file geometry and named architectural
// register indices used by the core and its register file.
package mips_cpu_definitions;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_COUNT      = 2 ** REG_ADDR_WIDTH;
    localparam int REG_DATA_WIDTH = 32;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;

    // Architectural register names from the MIPS o32 calling convention.
    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_AT   = 5'd1;
    localparam reg_addr_t REG_V0   = 5'd2;
    localparam reg_addr_t REG_V1   = 5'd3;
    localparam reg_addr_t REG_A0   = 5'd4;
    localparam reg_addr_t REG_T0   = 5'd8;
    localparam reg_addr_t REG_S0   = 5'd16;
    localparam reg_addr_t REG_GP   = 5'd28;
    localparam reg_addr_t REG_SP   = 5'd29;
    localparam reg_addr_t REG_FP   = 5'd30;
    localparam reg_addr_t REG_RA   = 5'd31;

endpackage : mips_cpu_definitions

// File: rtl/mips_cpu_regfile_if.sv
// Bundle of the register-file access signals as seen between the CPU datapath
// (master) and the register file (slave).
interface mips_cpu_regfile_if;
    import mips_cpu_definitions::*;

    reg_addr_t read_addr1;
    reg_addr_t read_addr2;
    reg_addr_t write_addr;
    reg_data_t write_data;
    logic      write_en;
    reg_data_t read_data1;
    reg_data_t read_data2;

    modport master (
        output read_addr1,
        output read_addr2,
        output write_addr,
        output write_data,
        output write_en,
        input  read_data1,
        input  read_data2
    );

    modport slave (
        input  read_addr1,
        input  read_addr2,
        input  write_addr,
        input  write_data,
        input  write_en,
        output read_data1,
        output read_data2
    );

endinterface : mips_cpu_regfile_if

// File: rtl/mips_cpu_regfile.sv
// 32 x 32-bit MIPS register file: two combinational read ports, one synchronous
// write port, $0 hardwired to zero. Flat positional ports so the core can bind by order.
module mips_cpu_regfile #(
    parameter int DATA_WIDTH = mips_cpu_definitions::REG_DATA_WIDTH,
    parameter int ADDR_WIDTH = mips_cpu_definitions::REG_ADDR_WIDTH,
    parameter int REG_COUNT  = mips_cpu_definitions::REG_COUNT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_addr1,
    input  logic [ADDR_WIDTH-1:0] read_addr2,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_en,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
    logic                  w_write_ok;

    assign w_write_ok = write_en && (write_addr != '0);

    // NOTE: the array is reset so every register is driven to a known value; this
    // forces flops rather than a RAM macro, which is acceptable at 32 entries.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                // NOTE: non-blocking assignment so every reader in this edge sees pre-edge state.
                r_regs[i] <= '0;
            end
        end else if (w_write_ok) begin
            r_regs[write_addr] <= write_data;
        end
    end

    // No write bypass: a same-cycle read returns the old value until the edge.
    assign read_data1 = (read_addr1 == '0) ? '0 : r_regs[read_addr1];
    assign read_data2 = (read_addr2 == '0) ? '0 : r_regs[read_addr2];

endmodule : mips_cpu_regfile

// File: tb/tb_mips_cpu_regfile.sv
// Directed self-checking bench for mips_cpu_regfile: reset, write/read, $0,
// write-enable gating, read-during-write, reset priority and a full sweep.
`timescale 1ns/1ps
module tb_mips_cpu_regfile;
    import mips_cpu_definitions::*;

    logic clk;
    logic rst_n;
    int   n_compared;
    int   n_mismatched;

    mips_cpu_regfile_if rf_if ();

    mips_cpu_regfile dut (
        .clk        (clk),
        .reset      (rst_n),
        .read_addr1 (rf_if.read_addr1),
        .read_addr2 (rf_if.read_addr2),
        .write_addr (rf_if.write_addr),
        .write_data (rf_if.write_data),
        .write_en   (rf_if.write_en),
        .read_data1 (rf_if.read_data1),
        .read_data2 (rf_if.read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_reg(input reg_addr_t addr, input reg_data_t data);
        rf_if.write_addr = addr;
        rf_if.write_data = data;
        rf_if.write_en   = 1'b1;
        @(posedge clk);
        #1;
        rf_if.write_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        rf_if.write_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < REG_COUNT; i++) begin
            rf_if.read_addr1 = reg_addr_t'(i);
            rf_if.read_addr2 = reg_addr_t'(REG_COUNT - 1 - i);
            #1;
            n_compared += 2;
            if (rf_if.read_data1 !== 32'h0000_0000) begin
                n_mismatched++;
                $display("FAIL reset_rd1[%0d]: got %h expected 00000000", i, rf_if.read_data1);
            end
            if (rf_if.read_data2 !== 32'h0000_0000) begin
                n_mismatched++;
                $display("FAIL reset_rd2[%0d]: got %h expected 00000000", REG_COUNT - 1 - i, rf_if.read_data2);
            end
        end
    endtask

    task automatic test_basic_write();
        write_reg(REG_V0, 32'hDEAD_BEEF);
        rf_if.read_addr1 = REG_V0;
        rf_if.read_addr2 = REG_V0;
        #1;
        n_compared += 2;
        if (rf_if.read_data1 !== 32'hDEAD_BEEF) begin
            n_mismatched++;
            $display("FAIL basic_rd1: got %h expected deadbeef", rf_if.read_data1);
        end
        if (rf_if.read_data2 !== 32'hDEAD_BEEF) begin
            n_mismatched++;
            $display("FAIL basic_rd2: got %h expected deadbeef", rf_if.read_data2);
        end
    endtask

    task automatic test_zero_reg();
        write_reg(REG_ZERO, 32'h1234_5678);
        rf_if.read_addr1 = REG_ZERO;
        rf_if.read_addr2 = REG_ZERO;
        #1;
        n_compared += 2;
        if (rf_if.read_data1 !== 32'h0000_0000) begin
            n_mismatched++;
            $display("FAIL zero_rd1: got %h expected 00000000", rf_if.read_data1);
        end
        if (rf_if.read_data2 !== 32'h0000_0000) begin
            n_mismatched++;
            $display("FAIL zero_rd2: got %h expected 00000000", rf_if.read_data2);
        end
    endtask

    task automatic test_write_enable();
        rf_if.write_addr = 5'd5;
        rf_if.write_data = 32'hFFFF_FFFF;
        rf_if.write_en   = 1'b0;
        @(posedge clk);
        #1;
        rf_if.read_addr1 = 5'd5;
        rf_if.read_addr2 = REG_V0;
        #1;
        n_compared += 2;
        if (rf_if.read_data1 !== 32'h0000_0000) begin
            n_mismatched++;
            $display("FAIL we_gate_r5: got %h expected 00000000", rf_if.read_data1);
        end
        if (rf_if.read_data2 !== 32'hDEAD_BEEF) begin
            n_mismatched++;
            $display("FAIL we_gate_r2: got %h expected deadbeef", rf_if.read_data2);
        end
    endtask

    task automatic test_read_during_write();
        write_reg(5'd7, 32'h1111_1111);
        rf_if.read_addr1 = 5'd7;
        rf_if.read_addr2 = 5'd7;
        rf_if.write_addr = 5'd7;
        rf_if.write_data = 32'h2222_2222;
        rf_if.write_en   = 1'b1;
        #1;
        n_compared += 2;
        if (rf_if.read_data1 !== 32'h1111_1111) begin
            n_mismatched++;
            $display("FAIL rdw_before_rd1: got %h expected 11111111", rf_if.read_data1);
        end
        if (rf_if.read_data2 !== 32'h1111_1111) begin
            n_mismatched++;
            $display("FAIL rdw_before_rd2: got %h expected 11111111", rf_if.read_data2);
        end
        @(posedge clk);
        #1;
        rf_if.write_en = 1'b0;
        n_compared++;
        if (rf_if.read_data1 !== 32'h2222_2222) begin
            n_mismatched++;
            $display("FAIL rdw_after_rd1: got %h expected 22222222", rf_if.read_data1);
        end
    endtask

    task automatic test_reset_priority();
        write_reg(5'd9, 32'h0BAD_F00D);
        rf_if.read_addr1 = 5'd9;
        rf_if.read_addr2 = 5'd3;
        // Reset raised mid-cycle must not act before the edge.
        rst_n            = 1'b0;
        rf_if.write_addr = 5'd3;
        rf_if.write_data = 32'hAAAA_AAAA;
        rf_if.write_en   = 1'b1;
        #1;
        n_compared++;
        if (rf_if.read_data1 !== 32'h0BAD_F00D) begin
            n_mismatched++;
            $display("FAIL sync_reset_pre_edge: got %h expected 0badf00d", rf_if.read_data1);
        end
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        rf_if.write_en = 1'b0;
        #1;
        n_compared += 2;
        if (rf_if.read_data2 !== 32'h0000_0000) begin
            n_mismatched++;
            $display("FAIL reset_prio_r3: got %h expected 00000000", rf_if.read_data2);
        end
        if (rf_if.read_data1 !== 32'h0000_0000) begin
            n_mismatched++;
            $display("FAIL reset_clears_r9: got %h expected 00000000", rf_if.read_data1);
        end
    endtask

    task automatic test_full_sweep();
        for (int i = 1; i < REG_COUNT; i++) begin
            write_reg(reg_addr_t'(i), 32'h5A00_0000 + 32'(i) * 32'h0001_0101);
        end
        for (int i = 0; i < REG_COUNT; i++) begin
            logic [31:0] exp1;
            logic [31:0] exp2;
            int          j;
            j    = REG_COUNT - 1 - i;
            exp1 = (i == 0) ? 32'h0 : 32'h5A00_0000 + 32'(i) * 32'h0001_0101;
            exp2 = (j == 0) ? 32'h0 : 32'h5A00_0000 + 32'(j) * 32'h0001_0101;
            rf_if.read_addr1 = reg_addr_t'(i);
            rf_if.read_addr2 = reg_addr_t'(j);
            #1;
            n_compared += 2;
            if (rf_if.read_data1 !== exp1) begin
                n_mismatched++;
                $display("FAIL sweep_rd1[%0d]: got %h expected %h", i, rf_if.read_data1, exp1);
            end
            if (rf_if.read_data2 !== exp2) begin
                n_mismatched++;
                $display("FAIL sweep_rd2[%0d]: got %h expected %h", j, rf_if.read_data2, exp2);
            end
        end
    endtask

    initial begin
        n_compared       = 0;
        n_mismatched     = 0;
        rst_n            = 1'b1;
        rf_if.read_addr1 = '0;
        rf_if.read_addr2 = '0;
        rf_if.write_addr = '0;
        rf_if.write_data = '0;
        rf_if.write_en   = 1'b0;
        @(negedge clk);

        test_reset();
        test_basic_write();
        test_zero_reg();
        test_write_enable();
        test_read_during_write();
        test_reset_priority();
        test_full_sweep();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_mips_cpu_regfile
